de_multiplexer: RTL and testbench

DE_MULTIPLEXER -- requirements
Module: de_multiplexer

---
 rtl/de_multiplexer.sv | 115 +++++++++++
 tb/tb_de_multiplexer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/de_multiplexer.sv
// rtl/de_multiplexer.sv - 1-to-2 registered demultiplexer with per-channel counters and sticky select error
//
// Routes a qualified input word to channel B (Select=0) or channel C (Select=1).
// Every output is registered, so a sampled input appears exactly one clock later.
// An illegal Select (2 or 3) with in_valid raises a sticky sel_err.
//
// Ports:
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   A_in       in   WIDTH   input data word
//   Select     in   2       route select: 0 -> B, 1 -> C, 2/3 -> illegal
//   in_valid   in   1       qualifies A_in/Select this cycle
//   clr_err    in   1       synchronous clear of sel_err
//   outB       out  WIDTH   channel-B data (holds between transfers)
//   outC       out  WIDTH   channel-C data (holds between transfers)
//   outB_valid out  1       one-cycle strobe: new data on outB
//   outC_valid out  1       one-cycle strobe: new data on outC
//   sel_err    out  1       sticky illegal-select flag
//   cntB       out  CNT_W   wrapping count of transfers routed to B
//   cntC       out  CNT_W   wrapping count of transfers routed to C

module de_multiplexer #(
  parameter int WIDTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A_in,
  input  logic [1:0]       Select,
  input  logic             in_valid,
  input  logic             clr_err,
  output logic [WIDTH-1:0] outB,
  output logic [WIDTH-1:0] outC,
  output logic             outB_valid,
  output logic             outC_valid,
  output logic             sel_err,
  output logic [CNT_W-1:0] cntB,
  output logic [CNT_W-1:0] cntC
);

  logic [WIDTH-1:0] out_b_q, out_b_d;
  logic [WIDTH-1:0] out_c_q, out_c_d;
  logic             out_b_valid_q, out_b_valid_d;
  logic             out_c_valid_q, out_c_valid_d;
  logic             sel_err_q, sel_err_d;
  logic [CNT_W-1:0] cnt_b_q, cnt_b_d;
  logic [CNT_W-1:0] cnt_c_q, cnt_c_d;

  logic take_b;
  logic take_c;
  logic take_bad;

  assign take_b   = in_valid && (Select == 2'd0);
  assign take_c   = in_valid && (Select == 2'd1);
  assign take_bad = in_valid && Select[1];

  always_comb begin
    out_b_d       = out_b_q;
    out_c_d       = out_c_q;
    cnt_b_d       = cnt_b_q;
    cnt_c_d       = cnt_c_q;
    sel_err_d     = sel_err_q;
    // Strobes are single-cycle: they fall unless re-armed by a transfer this cycle.
    out_b_valid_d = 1'b0;
    out_c_valid_d = 1'b0;

    if (take_b) begin
      out_b_d       = A_in;
      out_b_valid_d = 1'b1;
      cnt_b_d       = cnt_b_q + CNT_W'(1);
    end

    if (take_c) begin
      out_c_d       = A_in;
      out_c_valid_d = 1'b1;
      cnt_c_d       = cnt_c_q + CNT_W'(1);
    end

    // Setting has priority over clearing so a fresh error is never lost.
    if (take_bad) begin
      sel_err_d = 1'b1;
    end else if (clr_err) begin
      sel_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_b_q       <= '0;
      out_c_q       <= '0;
      out_b_valid_q <= 1'b0;
      out_c_valid_q <= 1'b0;
      sel_err_q     <= 1'b0;
      cnt_b_q       <= '0;
      cnt_c_q       <= '0;
    end else begin
      out_b_q       <= out_b_d;
      out_c_q       <= out_c_d;
      out_b_valid_q <= out_b_valid_d;
      out_c_valid_q <= out_c_valid_d;
      sel_err_q     <= sel_err_d;
      cnt_b_q       <= cnt_b_d;
      cnt_c_q       <= cnt_c_d;
    end
  end

  assign outB       = out_b_q;
  assign outC       = out_c_q;
  assign outB_valid = out_b_valid_q;
  assign outC_valid = out_c_valid_q;
  assign sel_err    = sel_err_q;
  assign cntB       = cnt_b_q;
  assign cntC       = cnt_c_q;

endmodule

// File: tb/tb_de_multiplexer.sv
// tb/tb_de_multiplexer.sv - directed self-checking bench for de_multiplexer
//
// Drives directed vectors one clock apart and compares every output against
// hand-computed values sampled 1 time unit after the rising edge.

module tb_de_multiplexer;

  localparam int WIDTH = 2;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] A_in;
  logic [1:0]       Select;
  logic             in_valid;
  logic             clr_err;
  logic [WIDTH-1:0] outB;
  logic [WIDTH-1:0] outC;
  logic             outB_valid;
  logic             outC_valid;
  logic             sel_err;
  logic [CNT_W-1:0] cntB;
  logic [CNT_W-1:0] cntC;

  int n_checks;
  int n_errors;

  de_multiplexer #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .A_in       (A_in),
    .Select     (Select),
    .in_valid   (in_valid),
    .clr_err    (clr_err),
    .outB       (outB),
    .outC       (outC),
    .outB_valid (outB_valid),
    .outC_valid (outC_valid),
    .sel_err    (sel_err),
    .cntB       (cntB),
    .cntC       (cntC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one input vector, clock it in, and return 1 unit after the edge.
  task automatic step(input logic v, input logic [1:0] sel, input logic [WIDTH-1:0] a, input logic clr);
    in_valid = v;
    Select   = sel;
    A_in     = a;
    clr_err  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [WIDTH-1:0] eb, input logic [WIDTH-1:0] ec,
                         input logic evb, input logic evc, input logic eerr,
                         input logic [CNT_W-1:0] ecb, input logic [CNT_W-1:0] ecc);
    chk({tag, ".outB"},       32'(outB),       32'(eb));
    chk({tag, ".outC"},       32'(outC),       32'(ec));
    chk({tag, ".outB_valid"}, 32'(outB_valid), 32'(evb));
    chk({tag, ".outC_valid"}, 32'(outC_valid), 32'(evc));
    chk({tag, ".sel_err"},    32'(sel_err),    32'(eerr));
    chk({tag, ".cntB"},       32'(cntB),       32'(ecb));
    chk({tag, ".cntC"},       32'(cntC),       32'(ecc));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    Select   = 2'd0;
    A_in     = '0;
    clr_err  = 1'b0;

    // Reset state, held across two edges with in_valid asserted.
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    // Channel B transfers.
    step(1'b1, 2'd0, 2'd0, 1'b0);
    chk_all("b0", 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0);
    step(1'b1, 2'd0, 2'd1, 1'b0);
    chk_all("b1", 2'd1, 2'd0, 1'b1, 1'b0, 1'b0, 8'd2, 8'd0);

    // Channel C back-to-back; B holds.
    step(1'b1, 2'd1, 2'd0, 1'b0);
    chk_all("c0", 2'd1, 2'd0, 1'b0, 1'b1, 1'b0, 8'd2, 8'd1);
    step(1'b1, 2'd1, 2'd1, 1'b0);
    chk_all("c1", 2'd1, 2'd1, 1'b0, 1'b1, 1'b0, 8'd2, 8'd2);

    // Illegal select sets sticky error, data and counters untouched.
    step(1'b1, 2'd2, 2'd3, 1'b0);
    chk_all("ill2", 2'd1, 2'd1, 1'b0, 1'b0, 1'b1, 8'd2, 8'd2);
    // Idle with legal-looking Select/A_in: everything holds.
    step(1'b0, 2'd0, 2'd2, 1'b0);
    step(1'b0, 2'd1, 2'd3, 1'b0);
    step(1'b0, 2'd0, 2'd0, 1'b0);
    chk_all("idle3", 2'd1, 2'd1, 1'b0, 1'b0, 1'b1, 8'd2, 8'd2);

    // Set beats clear; then a bare clear drops the flag.
    step(1'b1, 2'd3, 2'd2, 1'b1);
    chk_all("setwins", 2'd1, 2'd1, 1'b0, 1'b0, 1'b1, 8'd2, 8'd2);
    step(1'b0, 2'd0, 2'd0, 1'b1);
    chk_all("clr", 2'd1, 2'd1, 1'b0, 1'b0, 1'b0, 8'd2, 8'd2);

    // Alternating channels with no bubbles.
    step(1'b1, 2'd0, 2'd2, 1'b0);
    chk_all("altB", 2'd2, 2'd1, 1'b1, 1'b0, 1'b0, 8'd3, 8'd2);
    step(1'b1, 2'd1, 2'd3, 1'b0);
    chk_all("altC", 2'd2, 2'd3, 1'b0, 1'b1, 1'b0, 8'd3, 8'd3);
    step(1'b1, 2'd0, 2'd3, 1'b0);
    chk_all("altB2", 2'd3, 2'd3, 1'b1, 1'b0, 1'b0, 8'd4, 8'd3);

    // Fresh reset so the wrap test starts from zero.
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("rst2.cntB", 32'(cntB), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 255; i++) begin
      step(1'b1, 2'd0, WIDTH'(i), 1'b0);
    end
    chk_all("cnt255", 2'd2, 2'd0, 1'b1, 1'b0, 1'b0, 8'd255, 8'd0);
    step(1'b1, 2'd0, 2'd3, 1'b0);
    chk_all("wrap", 2'd3, 2'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);

    // Put non-zero state everywhere, then reset mid-cycle with a transfer pending.
    step(1'b1, 2'd1, 2'd2, 1'b0);
    step(1'b1, 2'd2, 2'd1, 1'b0);
    in_valid = 1'b1;
    Select   = 2'd0;
    A_in     = 2'd1;
    #3;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    @(posedge clk);
    #1;
    chk_all("rst_hold", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);

    // Release with idle input: no leftover strobe.
    in_valid = 1'b0;
    rst_n    = 1'b1;
    step(1'b0, 2'd0, 2'd1, 1'b0);
    chk_all("post_rst", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    // First transfer after reset is taken on the first edge.
    step(1'b1, 2'd1, 2'd3, 1'b0);
    chk_all("first_xfer", 2'd0, 2'd3, 1'b0, 1'b1, 1'b0, 8'd0, 8'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
